// File: rtl/node_link_buffer.sv
// Elastic link buffer. Words arriving on single-cycle CS strobes are queued
// in a small FIFO and replayed as single-cycle CS pulses separated by at
// least GAP idle cycles, so a slow downstream node is never overrun.
module node_link_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 8
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [WIDTH-1:0]         shiftInData,
    input  logic                     shiftInCS,
    input  logic                     clearOverflow,
    output logic [WIDTH-1:0]         shiftOutData,
    output logic                     shiftOutCS,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    // Gap counter only ever holds GAP-1 .. 0.
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             cs_q, cs_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic issue, pop, push, drop;

    // Pop/push decisions: a pop frees a slot at the same edge, so a write to
    // a full FIFO is still accepted when it coincides with a pop.
    always_comb begin
        issue = 1'b0;
        unique case (state_q)
            StIdle:  issue = 1'b1;
            StSend:  issue = (GAP == 32'd0);
            StHold:  issue = (gap_q == '0);
            default: issue = 1'b0;
        endcase
        pop  = issue && (count_q != '0);
        push = shiftInCS && ((count_q != FullCnt) || pop);
        drop = shiftInCS && !push;
    end

    // Output FSM next state, gap counter, occupancy and overflow.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cs_d    = 1'b0;
        data_d  = data_q;
        if (pop) begin
            state_d = StSend;
            cs_d    = 1'b1;
            data_d  = mem[rd_ptr_q];
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StSend: begin
                    if (GAP > 32'd0) begin
                        state_d = StHold;
                        gap_d   = GW'(GAP - 32'd1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHold: begin
                    if (gap_q == '0) state_d = StIdle;
                    else             gap_d   = gap_q - 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // Setting wins over clearing when both happen at one edge.
        ovf_d = drop ? 1'b1 : (clearOverflow ? 1'b0 : ovf_q);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cs_q     <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            cs_q     <= cs_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= shiftInData;
    end

    assign shiftOutData = data_q;
    assign shiftOutCS   = cs_q;
    assign count        = count_q;
    assign full         = (count_q == FullCnt);
    assign empty        = (count_q == '0);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_node_link_buffer.sv
// Bench for node_link_buffer: two instances (GAP=8 and GAP=0) share the same
// stimulus; a queue-and-timestamp model predicts every output each cycle.
module tb_node_link_buffer;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         resetN = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_cs = 1'b0;
    logic         in_clr = 1'b0;

    logic [W-1:0] data0, data1;
    logic         cs0, cs1, full0, full1, empty0, empty1, ovf0, ovf1;
    logic [2:0]   cnt0, cnt1;

    int n_total = 0;
    int n_pass  = 0;

    node_link_buffer #(.WIDTH(W), .DEPTH(D), .GAP(8)) u_dut0 (
        .clk(clk), .resetN(resetN), .shiftInData(in_data), .shiftInCS(in_cs),
        .clearOverflow(in_clr), .shiftOutData(data0), .shiftOutCS(cs0),
        .count(cnt0), .full(full0), .empty(empty0), .overflow(ovf0)
    );

    node_link_buffer #(.WIDTH(W), .DEPTH(D), .GAP(0)) u_dut1 (
        .clk(clk), .resetN(resetN), .shiftInData(in_data), .shiftInCS(in_cs),
        .clearOverflow(in_clr), .shiftOutData(data1), .shiftOutCS(cs1),
        .count(cnt1), .full(full1), .empty(empty1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a queue per instance plus the earliest edge at which
    // the next pulse may be emitted (last pop edge + GAP + 1).
    int           gaps [2] = '{8, 0};
    logic [W-1:0] mbuf [2][D];
    int           mhead [2] = '{0, 0};
    int           msize [2] = '{0, 0};
    longint       mnext [2] = '{0, 0};
    logic         exp_cs [2] = '{1'b0, 1'b0};
    logic [W-1:0] exp_data [2] = '{'0, '0};
    logic         exp_ovf [2] = '{1'b0, 1'b0};
    longint       mcyc = 0;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                mhead[i] = 0; msize[i] = 0; mnext[i] = 0;
                exp_cs[i] = 1'b0; exp_data[i] = '0; exp_ovf[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit pop, acc;
                pop = (msize[i] > 0) && (mcyc >= mnext[i]);
                acc = in_cs && ((msize[i] < D) || pop);
                exp_cs[i] = pop;
                if (pop) begin
                    exp_data[i] = mbuf[i][mhead[i]];
                    mhead[i] = (mhead[i] + 1) % D;
                    msize[i]--;
                    mnext[i] = mcyc + gaps[i] + 1;
                end
                if (acc) begin
                    mbuf[i][(mhead[i] + msize[i]) % D] = in_data;
                    msize[i]++;
                end
                if (in_cs && !acc) exp_ovf[i] = 1'b1;
                else if (in_clr)   exp_ovf[i] = 1'b0;
            end
            mcyc++;
        end
    end

    task automatic cmp_inst(input int i, input logic [W-1:0] d, input logic cs,
                            input logic [2:0] c, input logic f, input logic e,
                            input logic o);
        chk($sformatf("cs%0d", i), cs, exp_cs[i]);
        chk($sformatf("data%0d", i), d, exp_data[i]);
        chk($sformatf("count%0d", i), c, msize[i]);
        chk($sformatf("full%0d", i), f, msize[i] == D);
        chk($sformatf("empty%0d", i), e, msize[i] == 0);
        chk($sformatf("overflow%0d", i), o, exp_ovf[i]);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        cmp_inst(0, data0, cs0, cnt0, full0, empty0, ovf0);
        cmp_inst(1, data1, cs1, cnt1, full1, empty1, ovf1);
    end

    task automatic step(input logic cs, input logic [W-1:0] d, input logic clr);
        @(negedge clk);
        in_cs = cs; in_data = d; in_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs", cs0, 1'b0);
        chk("rst_count", cnt0, 3'd0);
        chk("rst_empty", empty0, 1'b1);
        chk("rst_full", full0, 1'b0);
        chk("rst_ovf", ovf0, 1'b0);
        chk("rst_data", data0, 32'd0);
        resetN = 1'b1;

        // Single word latency.
        step(1'b1, 32'd42, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t1_count1", cnt0, 3'd1);
        chk("t1_cs_early", cs0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t1_cs", cs0, 1'b1);
        chk("t1_data", data0, 32'd42);
        chk("t1_count0", cnt0, 3'd0);
        step(1'b0, '0, 1'b0);
        chk("t1_cs_low", cs0, 1'b0);
        chk("t1_hold", data0, 32'd42);
        chk("t1_empty", empty0, 1'b1);
        idle(12);

        // Six words into a GAP=8 buffer: the sixth is dropped.
        for (int w = 1; w <= 6; w++) step(1'b1, w, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t2_ovf", ovf0, 1'b1);
        chk("t2_count", cnt0, 3'd4);
        chk("t2_ovf_gap0", ovf1, 1'b0);
        chk("t2_count_gap0", cnt1, 3'd1);
        idle(4);
        step(1'b0, '0, 1'b1);
        chk("t2_second_cs", cs0, 1'b1);
        chk("t2_second_data", data0, 32'd2);
        step(1'b0, '0, 1'b0);
        chk("t2_cleared", ovf0, 1'b0);
        idle(40);

        // Clear coinciding with a drop, then a write coinciding with a pop.
        for (int w = 11; w <= 15; w++) step(1'b1, w, 1'b0);
        step(1'b1, 32'd16, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t3_set_wins", ovf0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("t3_clear", ovf0, 1'b0);
        chk("t3_full", full0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 32'd99, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t3_count", cnt0, 3'd4);
        chk("t3_ovf", ovf0, 1'b0);
        chk("t3_cs", cs0, 1'b1);
        chk("t3_data", data0, 32'd12);
        idle(60);

        // Back-to-back emission with GAP=0.
        step(1'b1, 32'hA1, 1'b0);
        step(1'b1, 32'hB2, 1'b0);
        step(1'b1, 32'hC3, 1'b0);
        chk("t4_cs_a", cs1, 1'b1);
        chk("t4_a", data1, 32'hA1);
        step(1'b0, '0, 1'b0);
        chk("t4_cs_b", cs1, 1'b1);
        chk("t4_b", data1, 32'hB2);
        step(1'b0, '0, 1'b0);
        chk("t4_cs_c", cs1, 1'b1);
        chk("t4_c", data1, 32'hC3);
        step(1'b0, '0, 1'b0);
        chk("t4_cs_end", cs1, 1'b0);
        idle(40);

        // Asynchronous reset while holding with two words queued.
        step(1'b1, 32'd1, 1'b0);
        step(1'b1, 32'd2, 1'b0);
        step(1'b1, 32'd3, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t5_queued", cnt0, 3'd2);
        #2 resetN = 1'b0;
        #1;
        chk("t5_cs", cs0, 1'b0);
        chk("t5_count", cnt0, 3'd0);
        chk("t5_empty", empty0, 1'b1);
        chk("t5_ovf", ovf0, 1'b0);
        chk("t5_data", data0, 32'd0);
        step(1'b0, '0, 1'b0);
        resetN = 1'b1;
        idle(3);
        step(1'b1, 32'd7, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t5_count1", cnt0, 3'd1);
        step(1'b0, '0, 1'b0);
        chk("t5_cs7", cs0, 1'b1);
        chk("t5_data7", data0, 32'd7);
        idle(12);

        // Randomised traffic with alternating heavy and light load.
        for (int n = 0; n < 3000; n++) begin
            int unsigned pct;
            pct = ((n / 200) % 2 == 0) ? 75 : 12;
            step($urandom_range(99) < pct, $urandom, $urandom_range(19) == 0);
            if ($urandom_range(499) == 0) begin
                #2 resetN = 1'b0;
                @(negedge clk);
                resetN = 1'b1;
            end
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/node_link_buffer.md
Name: node_link_buffer

Overview:
- Elastic link buffer between two one-dimensional network nodes, or between a local source and a node's shiftIn port.
- Captures single-cycle CS-qualified data words into a DEPTH-entry FIFO.
- Re-emits the words as single-cycle CS pulses with a guaranteed minimum spacing, so the downstream node never sees pulses closer together than it can process.
- Reports occupancy and a sticky overflow flag for drops.

Parameters:
WIDTH, 32, data word width
DEPTH, 4, FIFO entries; power of two, >= 2
GAP, 8, idle cycles forced after every output pulse (>= 0); pulse-to-pulse spacing = GAP+1 cycles

Ports:
clk  input  1  single clock; all state updates on rising edge
resetN  input  1  asynchronous, active-low reset
shiftInData  input  WIDTH  incoming word, valid when shiftInCS=1
shiftInCS  input  1  write strobe; each cycle high = one word
clearOverflow  input  1  synchronous clear of overflow
shiftOutData  output  WIDTH  word presented to downstream node
shiftOutCS  output  1  one-cycle strobe qualifying shiftOutData
count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a write was dropped

Behaviour:
- Reset: while resetN=0, all of the following take effect immediately and asynchronously:
  - shiftOutCS=0, shiftOutData=0, count=0, empty=1, full=0, overflow=0.
  - Read/write pointers = 0; gap counter = 0; state = IDLE.
  - Mid-operation reset discards all queued words and any pulse in flight.
- Write:
  - A word is accepted at edge k when shiftInCS=1 and either (count<DEPTH) or (a pop occurs at the same edge k).
  - Storage order is FIFO; pointers wrap modulo DEPTH.
- Drop: shiftInCS=1 with count==DEPTH and no pop at that edge.
  - The word is discarded, count is unchanged, and overflow is set at that edge.
- Overflow:
  - Stays at 1 until clearOverflow=1 is sampled at an edge.
  - If set and clear occur at the same edge, set wins and overflow stays 1.
- Output FSM states: IDLE, SEND, HOLD.
  - IDLE: if count>0 at edge, go to SEND. At that edge: pop, shiftOutData <= head, shiftOutCS <= 1.
  - SEND (one cycle): at next edge, shiftOutCS <= 0.
    - If GAP>0: gap counter <= GAP-1, go to HOLD.
    - If GAP=0 and count>0: pop again immediately (CS remains 1, new data).
    - If GAP=0 and count==0: go to IDLE.
  - HOLD: decrement gap counter each edge. In the cycle where gap counter==0, that edge behaves as IDLE: pop to SEND if count>0, else go to IDLE.
  - shiftOutData holds the last emitted word when shiftOutCS=0; it is never zeroed except by reset.
- Latency: a word written at edge k into an empty, IDLE buffer appears with shiftOutCS=1 during the cycle following edge k+1 (pop at edge k+1). Words are never emitted in the same cycle they are written.
- Spacing: while the FIFO is non-empty, consecutive shiftOutCS rising edges are exactly GAP+1 cycles apart.
- count update: count_next = count + accepted_write − pop.
- Flags: full and empty are combinational from count.

Test Plan:
- Reset release, then shiftInData=42 with shiftInCS=1 for one cycle (edge k) -> count=1 after edge k; shiftOutCS=1 for exactly one cycle after edge k+1 with shiftOutData=42; count=0, empty=1 afterwards; shiftOutData stays 42.
- DEPTH=4, GAP=8: write 5 words (1..5) on consecutive edges 1..5 -> no overflow; count peaks at 4; outputs are 1,2,3,4,5 with CS pulses starting after edges 2, 11, 20, 29, 38.
- Same configuration with a 6th word at edge 6 -> word 6 dropped, overflow=1, count=4; outputs are 1..5 only. Assert clearOverflow for one cycle -> overflow=0. Assert clearOverflow at the same edge as a new drop -> overflow stays 1.
- Full FIFO with a write coinciding with a pop edge -> word accepted, count stays 4, overflow stays 0, and the word emerges in order.
- GAP=0 configuration: write 3 words back-to-back -> shiftOutCS held high for 3 consecutive cycles carrying the 3 words in order.
- Assert resetN=0 mid-HOLD with 2 words queued -> shiftOutCS=0, count=0, overflow=0 immediately, without waiting for a clock edge. After release, no stale words are emitted; a new word 7 emits with the normal 2-edge latency.
